// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus delay flop; one-cycle pulse per rising edge of d.
module sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);
  localparam int DEPTH = 3;
  logic [DEPTH-1:0] s_q, s_d;
  always_comb s_d = {s_q[DEPTH-2:0], d};
  always_ff @(posedge clk_in) s_q <= rst ? '0 : s_d;
  assign rise = s_q[1] & ~s_q[2];
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: tick-driven PWM generator with staged period/duty reload at period wrap.
module pwm_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_src,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
  output logic             pwm_out,
  output logic             period_end,
  output logic             load_ack
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, per_act_q, per_act_d, duty_act_q, duty_act_d;
  logic [WIDTH-1:0] per_stg_q, per_stg_d, duty_stg_q, duty_stg_d;
  logic pend_q, pend_d, pwm_q, pwm_d, pe_q, pe_d, ack_q, ack_d;
  logic tick, wrap;
  sync_edge u_sync (.clk_in(clk_in), .rst(rst), .d(tick_src), .rise(tick));
  assign wrap = tick && cnt_q == per_act_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    per_stg_d  = per_stg_q;
    duty_stg_d = duty_stg_q;
    pend_d     = pend_q;
    pe_d       = 1'b0;
    ack_d      = 1'b0;
    pwm_d      = 1'b0;
    if (state_q == IDLE) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      if (en) begin
        state_d    = RUN;
        per_act_d  = period;
        duty_act_d = duty;
        pwm_d      = duty != '0;
      end
    end else if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      if (load && !wrap) begin
        per_stg_d  = period;
        duty_stg_d = duty;
        pend_d     = 1'b1;
      end
      if (wrap) begin
        cnt_d  = '0;
        pe_d   = 1'b1;
        ack_d  = load || pend_q;
        pend_d = 1'b0;
        // a load on the wrap cycle bypasses staging and wins over older staged values
        per_act_d  = load ? period : pend_q ? per_stg_q : per_act_q;
        duty_act_d = load ? duty : pend_q ? duty_stg_q : duty_act_q;
      end else if (tick) begin
        cnt_d = cnt_q + 1'b1;
      end
      pwm_d = cnt_d < duty_act_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      per_stg_q  <= '0;
      duty_stg_q <= '0;
      pend_q     <= 1'b0;
      pwm_q      <= 1'b0;
      pe_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      per_stg_q  <= per_stg_d;
      duty_stg_q <= duty_stg_d;
      pend_q     <= pend_d;
      pwm_q      <= pwm_d;
      pe_q       <= pe_d;
      ack_q      <= ack_d;
    end
  end
  assign pwm_out    = pwm_q;
  assign period_end = pe_q;
  assign load_ack   = ack_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed scenarios plus random stimulus checked cycle-by-cycle against a behavioural model.
module tb_pwm_gen;
  localparam int W = 16;
  logic clk_in = 1'b0;
  logic rst, en, tick_src, load;
  logic [W-1:0] period, duty;
  logic pwm_out, period_end, load_ack;
  int errors = 0, checks = 0;
  int hp = 0, tcnt = 0, ncyc = 0, last_pe = -1, gap = 0;
  bit m1, m2, m3, run, pend, e_pwm, e_pe, e_ack;
  int cnt, per, dty, sp, sd;
  always #5 clk_in = ~clk_in;
  pwm_gen #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .tick_src(tick_src), .period(period), .duty(duty),
    .load(load), .pwm_out(pwm_out), .period_end(period_end), .load_ack(load_ack)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, ncyc, got, exp);
    end
  endtask
  // a tick_src rise first sampled at edge k becomes a counter step at edge k+2
  task automatic model_edge();
    bit tick, wr;
    tick = m2 && !m3;
    m3 = m2; m2 = m1; m1 = tick_src;
    e_pe = 0; e_ack = 0;
    if (rst) begin
      m1 = 0; m2 = 0; m3 = 0; run = 0; pend = 0;
      cnt = 0; per = 0; dty = 0; sp = 0; sd = 0; e_pwm = 0;
    end else if (!run) begin
      cnt = 0; pend = 0; e_pwm = 0;
      if (en) begin
        run = 1; per = int'(period); dty = int'(duty); e_pwm = dty > 0;
      end
    end else if (!en) begin
      run = 0; cnt = 0; pend = 0; e_pwm = 0;
    end else begin
      wr = tick && cnt == per;
      if (wr) begin
        cnt = 0; e_pe = 1;
        if (load) begin per = int'(period); dty = int'(duty); e_ack = 1; end
        else if (pend) begin per = sp; dty = sd; e_ack = 1; end
        pend = 0;
      end else begin
        if (tick) cnt++;
        if (load) begin sp = int'(period); sd = int'(duty); pend = 1; end
      end
      e_pwm = cnt < dty;
    end
  endtask
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
      ncyc++;
      check("pwm_out", pwm_out, e_pwm);
      check("period_end", period_end, e_pe);
      check("load_ack", load_ack, e_ack);
      if (period_end) begin
        if (last_pe >= 0) gap = ncyc - last_pe;
        last_pe = ncyc;
      end
      if (hp != 0 && ++tcnt >= hp) begin
        tcnt = 0;
        tick_src = ~tick_src;
      end
    end
  endtask
  task automatic do_load(input int p, input int d);
    period = W'(p); duty = W'(d); load = 1;
    cyc();
    load = 0;
  endtask
  initial begin
    rst = 1; en = 0; load = 0; tick_src = 0; period = '0; duty = '0;
    cyc(3);
    rst = 0; period = 3; duty = 2; hp = 2; en = 1;
    cyc(70);
    check("gap_basic", gap, 16);
    do_load(3, 0);
    cyc(40);
    do_load(3, 5);
    cyc(40);
    check("gap_duty_limit", gap, 16);
    do_load(3, 2);
    cyc(30);
    wait_tick_phase();
    do_load(1, 1);
    last_pe = -1; gap = 0;
    cyc(60);
    check("gap_staged", gap, 8);
    do_load(3, 2);
    cyc(40);
    en = 0; cyc(); en = 1;
    cyc(30);
    rst = 1; cyc(); rst = 0;
    cyc(20);
    do_load(0, 1);
    last_pe = -1; gap = 0;
    cyc(40);
    check("gap_period0", gap, 4);
    hp = 0; tick_src = 1;
    cyc(30);
    hp = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) hp = $urandom_range(0, 3);
      en = $urandom_range(0, 24) != 0;
      rst = $urandom_range(0, 149) == 0;
      load = $urandom_range(0, 9) == 0;
      period = W'($urandom_range(0, 6));
      duty = W'($urandom_range(0, 8));
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  // waits (bounded) until the model sits at cnt=1 so the staged load lands mid-period
  task automatic wait_tick_phase();
    for (int i = 0; i < 64 && cnt != 1; i++) cyc();
    check("reach_cnt1", cnt, 1);
  endtask
endmodule
